// File: rtl/srcnt_share_sched_if.sv
// Scheduler <-> agents/counter bundle for srcnt_share_sched.
// master: requesting side (drives req, cnt_value); slave: the scheduler.
// SRCNT_SCHED_WDOG_EN adds the sticky wdog_err output.
interface srcnt_share_sched_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 4
);
   logic [NREQ-1:0]  req;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_start;
   logic             cnt_stop;
   logic [NREQ-1:0]  gnt;
   logic             busy;
   logic             done;
   logic [2:0]       done_id;
   logic             aborted;
`ifdef SRCNT_SCHED_WDOG_EN
   logic             wdog_err;

   modport master (output req, cnt_value,
                   input  cnt_start, cnt_stop, gnt, busy, done, done_id, aborted, wdog_err);
   modport slave  (input  req, cnt_value,
                   output cnt_start, cnt_stop, gnt, busy, done, done_id, aborted, wdog_err);
`else
   modport master (output req, cnt_value,
                   input  cnt_start, cnt_stop, gnt, busy, done, done_id, aborted);
   modport slave  (input  req, cnt_value,
                   output cnt_start, cnt_stop, gnt, busy, done, done_id, aborted);
`endif
endinterface

// File: rtl/srcnt_share_sched.sv
// Round-robin scheduler sharing one start/stop wrap counter among NREQ agents.
// Flow per grant: IDLE (arbitrate) -> START (start pulse) -> RUN (count
// RUN_WRAPS wraps) -> STOP (stop pulse + done) -> DRAIN (STOP_LAT quiet cycles).
// Optional watchdog: define SRCNT_SCHED_WDOG_EN to abort a RUN whose counter
// value has not moved for WDOG_CYC cycles and raise sticky wdog_err.
module srcnt_share_sched #(
   parameter int NREQ      = 4,
   parameter int CNT_W     = 4,
   parameter int CNT_MAX   = 13,
   parameter int RUN_WRAPS = 2,
   parameter int STOP_LAT  = 2,
   parameter int WDOG_CYC  = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   srcnt_share_sched_if.slave  bus
);

   // Elaboration-time range guard for the parameters.
   if (NREQ < 2 || NREQ > 8 || RUN_WRAPS < 1 || RUN_WRAPS > 15 ||
       STOP_LAT < 1 || STOP_LAT > 255 || WDOG_CYC < 1 || WDOG_CYC > 255 ||
       CNT_MAX < 0) begin : g_param_chk
      $error("srcnt_share_sched: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_STOP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [2:0]      idx_q, idx_d;      // granted requester
   logic [2:0]      ptr_q, ptr_d;      // round-robin start point
   logic [3:0]      wrap_q, wrap_d;    // wraps seen in this grant, saturating
   logic [7:0]      drain_q, drain_d;
   logic            aborted_q, aborted_d;

`ifdef SRCNT_SCHED_WDOG_EN
   logic [CNT_W-1:0] prev_q, prev_d;   // counter value one cycle ago
   logic [7:0]       stall_q, stall_d; // cycles without counter movement
   logic             wdog_q, wdog_d;
`endif

   // Request vector widened to 8 so any 3-bit index is in range.
   logic [7:0] req8;
   logic       pick_vld;
   logic [2:0] pick_idx;
   logic [3:0] cand;
   logic       wrap_hit, wrap_done, withdrawn;
   logic [3:0] wrap_inc;

   assign req8 = 8'(bus.req);

   // Cyclic priority search: first set request at or after ptr_q.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = ptr_q;
      cand     = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + 4'(i);
         if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
         if (!pick_vld && req8[cand[2:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[2:0];
         end
      end
   end

   assign wrap_hit  = (bus.cnt_value == CNT_W'(CNT_MAX));
   assign wrap_inc  = (wrap_q == 4'hF) ? wrap_q : wrap_q + 4'd1;
   assign wrap_done = wrap_hit && (wrap_inc >= 4'(RUN_WRAPS));
   assign withdrawn = !req8[idx_q];

   // Next-state logic; withdrawal outranks a coincident final wrap.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      wrap_d    = wrap_q;
      drain_d   = drain_q;
      aborted_d = aborted_q;
`ifdef SRCNT_SCHED_WDOG_EN
      prev_d    = bus.cnt_value;
      stall_d   = stall_q;
      wdog_d    = wdog_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_d     = NREQ'(8'd1 << pick_idx);
               idx_d     = pick_idx;
               aborted_d = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            wrap_d  = '0;
`ifdef SRCNT_SCHED_WDOG_EN
            stall_d = '0;
`endif
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (wrap_hit) wrap_d = wrap_inc;
`ifdef SRCNT_SCHED_WDOG_EN
            stall_d = (bus.cnt_value != prev_q) ? 8'd0 : stall_q + 8'd1;
`endif
            if (withdrawn) begin
               aborted_d = 1'b1;
               gnt_d     = '0;
               state_d   = ST_STOP;
            end else if (wrap_done) begin
               aborted_d = 1'b0;
               gnt_d     = '0;
               state_d   = ST_STOP;
            end
`ifdef SRCNT_SCHED_WDOG_EN
            else if (stall_d >= 8'(WDOG_CYC)) begin
               aborted_d = 1'b1;
               wdog_d    = 1'b1;
               gnt_d     = '0;
               state_d   = ST_STOP;
            end
`endif
         end
         ST_STOP: begin
            ptr_d   = (idx_q == 3'(NREQ - 1)) ? 3'd0 : idx_q + 3'd1;
            drain_d = '0;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_q >= 8'(STOP_LAT - 1)) state_d = ST_IDLE;
            else                             drain_d = drain_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset drops the grant at once with no stop pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         wrap_q    <= '0;
         drain_q   <= '0;
         aborted_q <= 1'b0;
`ifdef SRCNT_SCHED_WDOG_EN
         prev_q    <= '0;
         stall_q   <= '0;
         wdog_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         wrap_q    <= wrap_d;
         drain_q   <= drain_d;
         aborted_q <= aborted_d;
`ifdef SRCNT_SCHED_WDOG_EN
         prev_q    <= prev_d;
         stall_q   <= stall_d;
         wdog_q    <= wdog_d;
`endif
      end
   end

   assign bus.cnt_start = (state_q == ST_START);
   assign bus.cnt_stop  = (state_q == ST_STOP);
   assign bus.done      = (state_q == ST_STOP);
   assign bus.done_id   = (state_q == ST_STOP) ? idx_q : 3'd0;
   assign bus.aborted   = (state_q == ST_STOP) && aborted_q;
   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
`ifdef SRCNT_SCHED_WDOG_EN
   assign bus.wdog_err  = wdog_q;
`endif

endmodule
